// File: rtl/imem_loader.sv
// Instruction-memory program loader: length-prefixed little-endian byte stream in, sequential word writes out.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam logic [31:0]     DEPTH   = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t      state;
    state_t      nextState;
    logic [7:0]  lenLo;
    logic [15:0] lenWords;
    logic [1:0]  lane;
    logic [23:0] asmWord;
    logic        xfer;
    logic        restart;
    logic        lastWord;
    logic [31:0] lenFull;
    logic        readyNxt;
    logic        weNxt;
    logic        busyNxt;
    logic        doneNxt;
    logic        errNxt;
    logic        coreRstNxt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csumAcc;
`endif

    assign xfer     = byte_valid & byte_ready;
    assign restart  = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
    assign lenFull  = 32'({byte_data, lenLo});
    assign lastWord = ((32'(word_count) + 32'd1) == 32'(lenWords));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; start only matters in the resting states
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) nextState = S_LEN0;
                else       nextState = state;
            end
            S_LEN0: begin
                if (xfer) nextState = S_LEN1;
                else      nextState = state;
            end
            S_LEN1: begin
                if (!xfer)                    nextState = state;
                else if (lenFull == 32'd0)    nextState = S_TAIL;
                else if (lenFull > DEPTH)     nextState = S_ERR;
                else                          nextState = S_DATA;
            end
            S_DATA: begin
                if (xfer && (lane == 2'd3)) nextState = S_WRITE;
                else                        nextState = state;
            end
            S_WRITE: begin
                if (lastWord) nextState = S_TAIL;
                else          nextState = S_DATA;
            end
            S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (!xfer)                     nextState = state;
                else if (byte_data == csumAcc) nextState = S_DONE;
                else                           nextState = S_ERR;
`else
                nextState = S_ERR;
`endif
            end
            default: nextState = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output can be registered
    always_comb begin
        readyNxt   = 1'b0;
        weNxt      = 1'b0;
        busyNxt    = 1'b0;
        doneNxt    = 1'b0;
        errNxt     = 1'b0;
        coreRstNxt = 1'b0;
        case (nextState)
            S_IDLE:  coreRstNxt = 1'b1;
            S_LEN0, S_LEN1, S_DATA, S_CSUM: begin
                readyNxt = 1'b1;
                busyNxt  = 1'b1;
            end
            S_WRITE: begin
                weNxt   = 1'b1;
                busyNxt = 1'b1;
            end
            S_DONE: begin
                doneNxt    = 1'b1;
                coreRstNxt = 1'b1;
            end
            S_ERR:   errNxt = 1'b1;
            default: readyNxt = 1'b0;
        endcase
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            byte_ready <= readyNxt;
            imem_we    <= weNxt;
            busy       <= busyNxt;
            done       <= doneNxt;
            err        <= errNxt;
            core_rst_n <= coreRstNxt;
        end
    end

    // Length capture, byte-lane assembly, write address/data and word counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lenLo      <= 8'h00;
            lenWords   <= 16'h0000;
            lane       <= 2'd0;
            asmWord    <= 24'h000000;
            imem_addr  <= {ADDR_W{1'b0}};
            imem_wdata <= 32'h0000_0000;
            word_count <= {(ADDR_W+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
            csumAcc    <= 8'h00;
`endif
        end else begin
            if (restart) begin
                word_count <= {(ADDR_W+1){1'b0}};
                lane       <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                csumAcc    <= 8'h00;
`endif
            end else if (state == S_WRITE) begin
                word_count <= word_count + CNT_ONE;
            end
            if ((state == S_LEN0) && xfer) begin
                lenLo <= byte_data;
            end
            if ((state == S_LEN1) && xfer) begin
                lenWords <= {byte_data, lenLo};
            end
            if ((state == S_DATA) && xfer) begin
                lane <= lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csumAcc <= csumAcc ^ byte_data;
`endif
                // The 4th byte goes straight into the write word, bypassing asmWord
                case (lane)
                    2'd0: asmWord[7:0]   <= byte_data;
                    2'd1: asmWord[15:8]  <= byte_data;
                    2'd2: asmWord[23:16] <= byte_data;
                    default: begin
                        imem_addr  <= word_count[ADDR_W-1:0];
                        imem_wdata <= {byte_data, asmWord};
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=4): table vectors, random streams against a stream-level model, hand corner cases.
module tb_imem_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0] lenLo;
        logic [7:0] lenHi;
        bit         expDone;
        bit         expErr;
        int         expWc;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    int          nChecks = 0;
    int          nFails  = 0;
    int          wrAddr[$];
    logic [31:0] wrData[$];
    logic [31:0] expWords[$];
    bit          mErr;
    int          mWc;
    logic        midBusy;
    int          midWc;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wrAddr.push_back(int'(imem_addr));
            wrData.push_back(imem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic bq_t buildStream(input int n, input bit corrupt);
        bq_t q;
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        if (n > DEPTH) return q;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            x = x ^ b;
        end
`ifdef LOADER_CHECKSUM_EN
        q.push_back(corrupt ? (x ^ 8'h5A) : x);
`else
        if (corrupt) q.push_back(x);
`endif
        return q;
    endfunction

    // Stream-level reference: length prefix, little-endian words, optional XOR trailer
    task automatic model(input bq_t bs);
        int n;
        n = int'({bs[1], bs[0]});
        expWords.delete();
        if (n > DEPTH) begin
            mErr = 1'b1;
            mWc  = 0;
        end else begin
            for (int i = 0; i < n; i++)
                expWords.push_back({bs[2+4*i+3], bs[2+4*i+2], bs[2+4*i+1], bs[2+4*i]});
            mWc  = n;
            mErr = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                for (int i = 0; i < 4 * n; i++) x = x ^ bs[2+i];
                if (bs.size() < 3 + 4 * n) mErr = 1'b1;
                else if (bs[2+4*n] != x)  mErr = 1'b1;
            end
`endif
        end
    endtask

    task automatic pulseStart(input string tag, input logic [7:0] firstByte);
        @(negedge clk);
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = firstByte;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        check({tag, "_start_corerst"}, 32'(core_rst_n), 32'd0);
        check({tag, "_start_busy"},    32'(busy),       32'd1);
        check({tag, "_start_ready"},   32'(byte_ready), 32'd1);
        check({tag, "_start_done"},    32'(done),       32'd0);
        check({tag, "_start_err"},     32'(err),        32'd0);
        check({tag, "_start_wc"},      32'(word_count), 32'd0);
    endtask

    task automatic sendBytes(input string tag, input bq_t bs, input bit stall, input int startCyc, output int cycles);
        int idx;
        int cyc;
        bit take;
        idx = 0;
        cyc = 0;
        while (idx < bs.size() && cyc < 2000) begin
            @(negedge clk);
            if (cyc == startCyc + 1) begin
                midBusy = busy;
                midWc   = int'(word_count);
            end
            start = (cyc == startCyc);
            if (stall && ($urandom_range(0, 3) == 0)) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = bs[idx];
            end
            take = byte_valid && byte_ready;
            @(posedge clk);
            if (take) idx++;
            cyc++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        start      = 1'b0;
        check({tag, "_send_complete"}, 32'(idx), 32'(bs.size()));
        cycles = cyc;
    endtask

    task automatic waitEnd(input string tag);
        int k;
        k = 0;
        while (!(done || err) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_end_reached"}, 32'(done | err), 32'd1);
    endtask

    task automatic runLoad(input string tag, input bq_t bs, input bit stall, input int startCyc);
        int cycles;
        int n;
        int expCyc;
        wrAddr.delete();
        wrData.delete();
        pulseStart(tag, bs[0]);
        sendBytes(tag, bs, stall, startCyc, cycles);
        waitEnd(tag);
        @(negedge clk);
        model(bs);
        check({tag, "_nwrites"}, 32'(wrAddr.size()), 32'(expWords.size()));
        for (int i = 0; i < expWords.size() && i < wrAddr.size(); i++) begin
            check({tag, "_addr"}, 32'(wrAddr[i]), 32'(i));
            check({tag, "_data"}, wrData[i], expWords[i]);
        end
        check({tag, "_done"},    32'(done),       32'(!mErr));
        check({tag, "_err"},     32'(err),        32'(mErr));
        check({tag, "_wc"},      32'(word_count), 32'(mWc));
        check({tag, "_corerst"}, 32'(core_rst_n), 32'(!mErr));
        check({tag, "_busy"},    32'(busy),       32'd0);
        if (!stall) begin
            n = int'({bs[1], bs[0]});
            if (n > DEPTH) expCyc = 2;
`ifdef LOADER_CHECKSUM_EN
            else expCyc = bs.size() + n;
`else
            else expCyc = bs.size() + ((n == 0) ? 0 : n - 1);
`endif
            check({tag, "_cycles"}, 32'(cycles), 32'(expCyc));
        end
        if (startCyc >= 0) begin
            check({tag, "_mid_busy"}, 32'(midBusy), 32'd1);
            check({tag, "_mid_wc"},   32'(midWc),   32'd1);
        end
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_ready"},   32'(byte_ready), 32'd0);
        check({tag, "_we"},      32'(imem_we),    32'd0);
        check({tag, "_addr"},    32'(imem_addr),  32'd0);
        check({tag, "_wdata"},   imem_wdata,      32'd0);
        check({tag, "_corerst"}, 32'(core_rst_n), 32'd0);
        check({tag, "_busy"},    32'(busy),       32'd0);
        check({tag, "_done"},    32'(done),       32'd0);
        check({tag, "_err"},     32'(err),        32'd0);
        check({tag, "_wc"},      32'(word_count), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        bq_t  bs;
        bq_t  plan;
        int   cycles;
        int   n;

        vecs[0] = '{8'h01, 8'h00, 1'b1, 1'b0, 1};
        vecs[1] = '{8'h02, 8'h00, 1'b1, 1'b0, 2};
        vecs[2] = '{8'h11, 8'h00, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h05, 8'h00, 1'b1, 1'b0, 5};
        vecs[4] = '{8'h10, 8'h00, 1'b1, 1'b0, 16};
        vecs[5] = '{8'h00, 8'h01, 1'b0, 1'b1, 0};
        vecs[6] = '{8'h0F, 8'h00, 1'b1, 1'b0, 15};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 0};

        // Reset state and release
        @(negedge clk);
        checkResetValues("rst");
        rst = 1'b1;
        #1;
        check("rel_corerst_before_edge", 32'(core_rst_n), 32'd0);
        @(negedge clk);
        check("rel_corerst", 32'(core_rst_n), 32'd1);
        check("rel_done",    32'(done),       32'd0);
        check("rel_err",     32'(err),        32'd0);
        check("rel_ready",   32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("rel_no_writes", 32'(wrAddr.size()), 32'd0);

        // Reference program with exact timing
        plan = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        plan.push_back(8'h90);
`endif
        wrAddr.delete();
        wrData.delete();
        pulseStart("plan", 8'h02);
        sendBytes("plan", plan, 1'b0, -1, cycles);
`ifndef LOADER_CHECKSUM_EN
        check("plan_we2",    32'(imem_we),   32'd1);
        check("plan_addr2",  32'(imem_addr), 32'd1);
        check("plan_wdata2", imem_wdata,     32'h0010_0093);
        check("plan_done_before", 32'(done), 32'd0);
        @(negedge clk);
`endif
        check("plan_done",    32'(done),       32'd1);
        check("plan_corerst", 32'(core_rst_n), 32'd1);
        check("plan_wc",      32'(word_count), 32'd2);
        check("plan_we_low",  32'(imem_we),    32'd0);
        check("plan_nwrites", 32'(wrAddr.size()), 32'd2);
        if (wrAddr.size() == 2) begin
            check("plan_w0_addr", 32'(wrAddr[0]), 32'd0);
            check("plan_w0_data", wrData[0], 32'h0000_0013);
            check("plan_w1_addr", 32'(wrAddr[1]), 32'd1);
            check("plan_w1_data", wrData[1], 32'h0010_0093);
        end

        // Table-driven lengths: over-capacity rejects, then recovery, N=DEPTH boundary
        for (int v = 0; v < 8; v++) begin
            n  = int'({vecs[v].lenHi, vecs[v].lenLo});
            bs = buildStream(n, 1'b0);
            runLoad($sformatf("vec%0d", v), bs, 1'b0, -1);
            check($sformatf("vec%0d_tbl_done", v), 32'(done),       32'(vecs[v].expDone));
            check($sformatf("vec%0d_tbl_err", v),  32'(err),        32'(vecs[v].expErr));
            check($sformatf("vec%0d_tbl_wc", v),   32'(word_count), 32'(vecs[v].expWc));
        end

        // Empty program
        bs = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        bs.push_back(8'h01);
        runLoad("n0_badcsum", bs, 1'b0, -1);
        check("n0_badcsum_err", 32'(err), 32'd1);
        bs = '{8'h00, 8'h00, 8'h00};
`endif
        runLoad("n0", bs, 1'b0, -1);
        check("n0_done", 32'(done), 32'd1);
        check("n0_wc",   32'(word_count), 32'd0);

        // Reset mid-load: one word written, partial state discarded
        bs = buildStream(2, 1'b0);
        plan.delete();
        for (int i = 0; i < 6; i++) plan.push_back(bs[i]);
        wrAddr.delete();
        wrData.delete();
        pulseStart("intr", plan[0]);
        sendBytes("intr", plan, 1'b0, -1, cycles);
        repeat (2) @(negedge clk);
        check("intr_nwrites", 32'(wrAddr.size()), 32'd1);
        if (wrAddr.size() > 0) check("intr_addr0", 32'(wrAddr[0]), 32'd0);
        check("intr_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        checkResetValues("intr_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("intr_corerst_after", 32'(core_rst_n), 32'd1);
        check("intr_nwrites_after", 32'(wrAddr.size()), 32'd1);
        runLoad("intr_restart", bs, 1'b0, -1);

        // Back-to-back bytes with a start pulse in the middle of DATA
        bs = buildStream(3, 1'b0);
        runLoad("midstart", bs, 1'b0, 7);

        // Randomized streams against the model
        for (int r = 0; r < 10; r++) begin
            bit corrupt;
`ifdef LOADER_CHECKSUM_EN
            corrupt = ($urandom_range(0, 3) == 0);
`else
            corrupt = 1'b0;
`endif
            bs = buildStream(int'($urandom_range(0, 18)), corrupt);
            runLoad($sformatf("rnd%0d", r), bs, 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory program loader for the RV32I pipeline. It is the write side of the instruction memory that the fetch stage reads. It accepts a length-prefixed little-endian byte stream, assembles 32-bit words, and writes them sequentially into instruction memory from word address 0. It holds the pipeline in reset for the whole load, then releases it so execution starts at PC 0 with the new image.

## Interface
- ADDR_W, 10, instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a load; ignored unless in IDLE, DONE or ERR
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_W  word address for the write
- imem_wdata  out  32  word to write
- core_rst_n  out  1  active-low reset to the pipeline (drives its rst)
- busy  out  1  load in progress
- done  out  1  sticky; last load completed OK
- err  out  1  sticky; last load failed
- word_count  out  ADDR_W+1  words written in the current or last load

## Operation
- A byte transfers on a rising edge with byte_valid=1 and byte_ready=1. Bytes offered while byte_ready=0 are not consumed; the sender holds them.
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then 4·N data bytes. Each word is sent LSB first.
- States:
  - IDLE: byte_ready=0, core_rst_n=1. On start, go to LEN0. Entry clears done, err and word_count, and drives core_rst_n=0.
  - LEN0: byte_ready=1. Latch LEN_LO, go to LEN1.
  - LEN1: byte_ready=1. Latch LEN_HI.
    - N=0: go to DONE.
    - N>DEPTH: go to ERR.
    - Otherwise go to DATA.
  - DATA: byte_ready=1. Shift the byte into a 2-bit-indexed byte lane. On the 4th byte, go to WRITE.
  - WRITE: byte_ready=0. Issue imem_we=1 with imem_addr=word_count[ADDR_W-1:0] and imem_wdata=the assembled word. Increment word_count. If word_count+1 == N, go to DONE (or CSUM, see Configuration); otherwise go back to DATA.
  - DONE: done=1, busy=0, core_rst_n=1. A new start is accepted here.
  - ERR: err=1, busy=0, core_rst_n held 0. Leaves only on start or rst.
- busy=1 in LEN0, LEN1, DATA, WRITE and CSUM.
- start while busy has no effect and does not restart the load.
- Simultaneous start and byte_valid in IDLE: only start is acted on. The first byte is taken in the next cycle, in LEN0.
- imem_addr never wraps: N>DEPTH is rejected before any write, and N=DEPTH writes addresses 0..DEPTH-1.

## Timing
- Reset values:
  - state IDLE
  - byte_ready 0, imem_we 0, imem_addr 0, imem_wdata 0
  - core_rst_n 0, busy 0, done 0, err 0, word_count 0
- core_rst_n rises on the first clock edge after rst deasserts (IDLE).
- All outputs are registered.
- Start to core_rst_n=0: 1 cycle.
- 4th data byte accepted → imem_we high in the next cycle for exactly 1 cycle.
- Peak throughput is 4 bytes per 5 cycles.
- Last imem_we cycle → done=1 and core_rst_n=1 on the following edge.
- Reset asserted mid-load: everything returns to reset values immediately. A partially assembled word is discarded and never written. Words already written remain in memory.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last WRITE, the loader enters CSUM (byte_ready=1) and takes one extra byte.
  - The byte is compared with the running XOR of all 4·N data bytes, LEN bytes excluded.
  - Match → DONE. Mismatch → ERR, with core_rst_n held 0.
  - With N=0 the CSUM byte is still expected and must equal 0x00.
- Not defined: there is no CSUM state and the last WRITE goes straight to DONE. No trailing byte is consumed.

## Test plan
- Reset release, no start: core_rst_n goes 0→1 one edge after rst rises. imem_we is never asserted. done=0, err=0.
- Stream 02 00 13 00 00 00 93 00 10 00 (plus checksum 0x90 when LOADER_CHECKSUM_EN is defined):
  - imem_we at addr 0 with 0x00000013.
  - imem_we at addr 1 with 0x00100093.
  - word_count=2, done=1, core_rst_n=1 one cycle after the 2nd write.
- With ADDR_W=4, stream 11 00: go to ERR with no imem_we, err=1, core_rst_n=0. A following start plus a valid stream recovers to DONE.
- Stream 00 00: go to DONE with no writes and word_count=0. With the checksum enabled, byte 0x00 is required first; byte 0x01 gives ERR instead.
- Stream interrupted after 6 bytes of an N=2 load by rst low for 1 cycle:
  - Exactly one imem_we (addr 0) has occurred.
  - All outputs are at their reset values.
  - A restart with a full stream writes both words correctly.
- byte_valid held high throughout a load, plus a start pulse mid-DATA: bytes stall only in WRITE cycles, and the start is ignored (busy stays 1, word_count is not cleared).
